// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter path.
// Contents:
//   PC_WIDTH        - width of every PC value
//   PC_RESET_VECTOR - fetch PC after reset; the TMR PC register resets to the same value
//   pc_t            - PC value type
//   fetch_state_e   - fetch sequencer states
//   pc_align        - forces a PC onto a word boundary
package pc_pkg;

  localparam int unsigned PC_WIDTH = 32;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t PC_RESET_VECTOR = 32'h0040_0000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } fetch_state_e;

  function automatic pc_t pc_align(input pc_t addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/response bus plus the valid/ready instruction
// stream to decode, bundled for the fetch sequencer.
// Signals:
//   imem_req/imem_addr/imem_gnt       - request channel (one outstanding at most)
//   imem_rvalid/imem_rdata            - response channel
//   inst_valid/inst_ready             - handshake to decode
//   inst_data/inst_pc                 - instruction word and its PC
// Modports:
//   master - the fetch sequencer
//   slave  - the memory port and decode stage seen as one agent
interface pc_fetch_sequencer_if;
  import pc_pkg::*;

  logic        imem_req;
  pc_t         imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  pc_t         inst_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/fetch_inst_buf.sv
// Single-entry valid/ready holding register for fetched instructions.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   flush                 - drop any held entry (redirect)
//   load, load_data/pc    - capture a new instruction
//   out_ready             - consumer accepts the held entry
//   out_valid/data/pc     - held entry
module fetch_inst_buf
  import pc_pkg::*;
#(
  parameter pc_t RESET_PC = PC_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic [31:0] load_data,
  input  pc_t         load_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output pc_t         out_pc
);

  // Flush beats load beats consume. Load and consume never coincide in
  // practice because the sequencer only requests into an empty/draining buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pc    <= RESET_PC;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (load)
        out_valid <= 1'b1;
      else if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (load && !flush) begin
        out_data <= load_data;
        out_pc   <= load_pc;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: owns the fetch PC, issues instruction-memory requests,
// hands instructions to decode and drives the TMR PC register.
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   pc_next, pc_hold            - drive to PC register (next value / keep)
//   pc_cur                      - voted PC returned by the PC register
//   pc_mismatch                 - sticky: pc_cur diverged from expected PC
//   redirect_valid/target       - branch/jump redirect
//   bus (master)                - imem request/response and decode stream
module pc_fetch_sequencer
  import pc_pkg::*;
#(
  parameter pc_t RESET_PC = PC_RESET_VECTOR,
  parameter pc_t PC_STEP  = 32'd4
) (
  input  logic                 clk,
  input  logic                 reset,
  output pc_t                  pc_next,
  output logic                 pc_hold,
  input  pc_t                  pc_cur,
  output logic                 pc_mismatch,
  input  logic                 redirect_valid,
  input  pc_t                  redirect_target,
  pc_fetch_sequencer_if.master bus
);

  fetch_state_e state, state_nxt;
  pc_t          fetch_pc, fetch_pc_nxt, fetch_pc_d1;
  logic         redir_take;
  logic         buf_load;

  assign bus.imem_addr = fetch_pc;

  // Only request when the buffer will have room by the time the response lands.
  assign bus.imem_req = (state == REQ) && (!bus.inst_valid || bus.inst_ready) && !redirect_valid;

  // IDLE exists purely to delay the first request; redirects there are ignored.
  assign redir_take = redirect_valid && (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    buf_load     = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (bus.imem_req && bus.imem_gnt)
          state_nxt = WAIT;
      end
      WAIT: begin
        // A redirect without the response leaves one stale response in flight.
        if (redir_take)
          state_nxt = bus.imem_rvalid ? REQ : DROP;
        else if (bus.imem_rvalid) begin
          buf_load     = 1'b1;
          fetch_pc_nxt = fetch_pc + PC_STEP;
          state_nxt    = REQ;
        end
      end
      DROP: begin
        if (bus.imem_rvalid)
          state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
    if (redir_take)
      fetch_pc_nxt = pc_align(redirect_target);
  end

  // A redirect always loads the PC register, even onto the current fetch_pc.
  assign pc_next = fetch_pc_nxt;
  assign pc_hold = !(redir_take || buf_load);

  // The PC register returns its value two cycles late, i.e. one cycle behind fetch_pc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_d1 <= RESET_PC;
      pc_mismatch <= 1'b0;
    end else begin
      fetch_pc_d1 <= fetch_pc;
      if (pc_cur != fetch_pc_d1)
        pc_mismatch <= 1'b1;
    end
  end

  fetch_inst_buf #(
    .RESET_PC (RESET_PC)
  ) u_inst_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (redir_take),
    .load      (buf_load),
    .load_data (bus.imem_rdata),
    .load_pc   (fetch_pc),
    .out_ready (bus.inst_ready),
    .out_valid (bus.inst_valid),
    .out_data  (bus.inst_data),
    .out_pc    (bus.inst_pc)
  );

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: memory responder, TMR PC register stand-in,
// and a transaction-level model of the expected instruction stream.
module tb_pc_fetch_sequencer;
  import pc_pkg::*;

  logic clk;
  logic reset;
  pc_t  pc_next;
  logic pc_hold;
  pc_t  pc_cur;
  logic pc_mismatch;
  logic redirect_valid;
  pc_t  redirect_target;

  pc_fetch_sequencer_if bus();

  pc_fetch_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .pc_next         (pc_next),
    .pc_hold         (pc_hold),
    .pc_cur          (pc_cur),
    .pc_mismatch     (pc_mismatch),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .bus             (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in PC register: loads pc_next unless held, then one more stage.
  pc_t  r1, r2;
  logic force_en;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      r1 <= PC_RESET_VECTOR;
      r2 <= PC_RESET_VECTOR;
    end else begin
      if (!pc_hold) r1 <= pc_next;
      r2 <= r1;
    end
  end
  assign pc_cur = force_en ? 32'hDEAD_BEEF : r2;

  typedef struct {
    pc_t         pc;
    logic [31:0] data;
  } ent_t;

  int   n_cmp, n_err;
  ent_t q[$];
  pc_t  gaddr[$];
  pc_t  apc[$];
  pc_t  exp_fetch;
  logic exp_mis;
  bit   outst, out_stale;
  pc_t  out_addr;
  int   dly;
  int   gnt_pct, ready_mode, rsp_delay;
  bit   last_req;

  function automatic logic [31:0] mem(input pc_t a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit redir, input pc_t tgt, input bit frc);
    bit   do_rvalid, do_gnt, granted, acc, load, outst_at_start;
    ent_t e;
    outst_at_start = outst;
    do_rvalid = outst && (dly == 0);
    do_gnt    = ($urandom_range(99) < gnt_pct);
    redirect_valid  = redir;
    redirect_target = tgt;
    force_en        = frc;
    bus.imem_gnt    = do_gnt;
    bus.imem_rvalid = do_rvalid;
    bus.imem_rdata  = do_rvalid ? mem(out_addr) : $urandom;
    bus.inst_ready  = (ready_mode == 2) ? ($urandom_range(99) < 70) : ready_mode[0];
    #1;
    last_req = bus.imem_req;
    granted  = bus.imem_req && do_gnt;
    if (bus.imem_req)
      chk("req_while_full", bus.inst_valid && !bus.inst_ready, 0);
    if (granted) begin
      chk("single_outstanding", outst_at_start, 0);
      chk("grant_addr", bus.imem_addr, exp_fetch);
      gaddr.push_back(bus.imem_addr);
    end
    acc = bus.inst_valid && bus.inst_ready && !redir;
    if (acc) begin
      apc.push_back(bus.inst_pc);
      if (q.size() == 0)
        chk("unexpected_inst", 1, 0);
      else begin
        e = q.pop_front();
        chk("inst_pc", bus.inst_pc, e.pc);
        chk("inst_data", bus.inst_data, e.data);
      end
    end
    load = do_rvalid && !out_stale && !redir;
    if (do_rvalid) begin
      outst = 1'b0;
      if (load) begin
        q.push_back('{pc: out_addr, data: mem(out_addr)});
        exp_fetch = out_addr + 32'd4;
      end
    end else if (outst) begin
      dly--;
    end
    if (redir) begin
      q.delete();
      exp_fetch = {tgt[31:2], 2'b00};
      if (outst) out_stale = 1'b1;
    end
    if (granted) begin
      outst     = 1'b1;
      out_stale = 1'b0;
      out_addr  = bus.imem_addr;
      dly       = (rsp_delay < 0) ? int'($urandom_range(3)) : rsp_delay;
    end
    chk("pc_next", pc_next, exp_fetch);
    chk("pc_hold", pc_hold, !(redir || load));
    if (frc) exp_mis = 1'b1;
    @(posedge clk);
    #1;
    chk("inst_valid", bus.inst_valid, q.size() != 0);
    chk("pc_mismatch", pc_mismatch, exp_mis);
  endtask

  task automatic do_reset(input bit keep_stale);
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    force_en = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.inst_ready = 1'b0;
    #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_imem_addr", bus.imem_addr, PC_RESET_VECTOR);
    chk("rst_inst_valid", bus.inst_valid, 0);
    chk("rst_inst_data", bus.inst_data, 0);
    chk("rst_inst_pc", bus.inst_pc, PC_RESET_VECTOR);
    chk("rst_pc_next", pc_next, PC_RESET_VECTOR);
    chk("rst_pc_hold", pc_hold, 1);
    chk("rst_pc_mismatch", pc_mismatch, 0);
    q.delete();
    exp_fetch = PC_RESET_VECTOR;
    exp_mis = 1'b0;
    if (keep_stale && outst) begin
      out_stale = 1'b1;
      dly = 0;
    end else begin
      outst = 1'b0;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic run_until_grants(input int n, input string tag, output int calls);
    calls = 0;
    while (gaddr.size() < n && calls < 60) begin
      cycle(1'b0, '0, 1'b0);
      calls++;
    end
    chk({tag, "_grant_timeout"}, gaddr.size() >= n, 1);
  endtask

  task automatic run_until_accepts(input int n, input string tag);
    int calls = 0;
    while (apc.size() < n && calls < 80) begin
      cycle(1'b0, '0, 1'b0);
      calls++;
    end
    chk({tag, "_accept_timeout"}, apc.size() >= n, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   calls;
    logic [31:0] held;
    n_cmp = 0; n_err = 0;
    outst = 1'b0; out_stale = 1'b0; out_addr = '0; dly = 0;
    gnt_pct = 100; ready_mode = 1; rsp_delay = 0;
    force_en = 1'b0;

    // Sequential fetch with an always-granting, one-cycle memory.
    do_reset(1'b0);
    gaddr.delete(); apc.delete();
    cycle(1'b0, '0, 1'b0);
    chk("t1_idle_no_req", last_req, 0);
    cycle(1'b0, '0, 1'b0);
    chk("t1_first_req", last_req, 1);
    run_until_accepts(3, "t1");
    chk("t1_addr0", gaddr[0], 32'h0040_0000);
    chk("t1_addr1", gaddr[1], 32'h0040_0004);
    chk("t1_addr2", gaddr[2], 32'h0040_0008);
    chk("t1_pc2", apc[2], 32'h0040_0008);

    // Decode stalls after the first instruction.
    do_reset(1'b0);
    ready_mode = 0;
    calls = 0;
    while (!bus.inst_valid && calls < 20) begin
      cycle(1'b0, '0, 1'b0);
      calls++;
    end
    chk("t2_valid_timeout", bus.inst_valid, 1);
    held = bus.inst_data;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b0);
      chk("t2_req_gated", last_req, 0);
      chk("t2_data_stable", bus.inst_data, held);
    end
    chk("t2_inst_pc", bus.inst_pc, 32'h0040_0000);
    ready_mode = 1;
    gaddr.delete();
    run_until_grants(1, "t2", calls);
    chk("t2_resume_addr", gaddr[0], 32'h0040_0004);

    // Redirect while waiting; the response arrives three cycles later.
    do_reset(1'b0);
    rsp_delay = 3;
    gaddr.delete(); apc.delete();
    run_until_grants(1, "t3a", calls);
    cycle(1'b1, 32'h0040_1003, 1'b0);
    gaddr.delete(); apc.delete();
    run_until_grants(1, "t3", calls);
    chk("t3_grant_delay", calls, 4);
    chk("t3_addr", gaddr[0], 32'h0040_1000);
    run_until_accepts(1, "t3");
    chk("t3_first_pc", apc[0], 32'h0040_1000);

    // Redirect coinciding with the response.
    do_reset(1'b0);
    rsp_delay = 0;
    gaddr.delete();
    run_until_grants(1, "t4a", calls);
    cycle(1'b1, 32'h0040_2000, 1'b0);
    chk("t4_no_valid", bus.inst_valid, 0);
    gaddr.delete(); apc.delete();
    run_until_grants(1, "t4", calls);
    chk("t4_addr", gaddr[0], 32'h0040_2000);
    chk("t4_grant_delay", calls, 1);

    // Wrap past the top of the address space (unaligned target).
    cycle(1'b1, 32'hFFFF_FFFE, 1'b0);
    gaddr.delete(); apc.delete();
    run_until_accepts(2, "t5");
    chk("t5_pc_top", apc[0], 32'hFFFF_FFFC);
    chk("t5_pc_wrap", apc[1], 32'h0000_0000);
    chk("t5_addr_wrap", gaddr[1], 32'h0000_0000);

    // Corrupt pc_cur for one cycle; the flag must stick.
    cycle(1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0);
    chk("t6_sticky", pc_mismatch, 1);

    // Asynchronous reset while a request is outstanding; the late response is ignored.
    rsp_delay = 3;
    gaddr.delete();
    run_until_grants(1, "t6a", calls);
    #2;
    do_reset(1'b1);
    rsp_delay = 0;
    gaddr.delete(); apc.delete();
    cycle(1'b0, '0, 1'b0);
    chk("t6_idle_no_req", last_req, 0);
    run_until_accepts(1, "t6");
    chk("t6_first_pc", apc[0], PC_RESET_VECTOR);

    // Randomized traffic against the stream model.
    do_reset(1'b0);
    gnt_pct = 70; ready_mode = 2; rsp_delay = -1;
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      bit   r;
      pc_t  t;
      r = ($urandom_range(99) < 8);
      t = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : pc_t'($urandom);
      cycle(r, t, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
